// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared definitions for the sprite descriptor table. Holds the
//                descriptor field layout, the register map, the CTRL bit
//                positions and the reset descriptor value.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    // Descriptor field layout: [31:25] dim, [24:20] id, [19:10] y, [9:0] x
    localparam int DESC_DIM_MSB = 31;
    localparam int DESC_DIM_LSB = 25;
    localparam int DESC_ID_MSB  = 24;
    localparam int DESC_ID_LSB  = 20;
    localparam int DESC_Y_MSB   = 19;
    localparam int DESC_Y_LSB   = 10;
    localparam int DESC_X_MSB   = 9;
    localparam int DESC_X_LSB   = 0;

    // Register map (word addresses)
    localparam logic [2:0] ADDR_CTRL   = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    // CTRL register bits
    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_AUTO_BIT   = 1;

    // Reset descriptor: y = 1023 parks the sprite off-screen
    localparam logic [31:0] SPRITE_RESET_DESC = 32'h000F_FC00;

    localparam int VBLANK_LINE_DEFAULT = 480;

    typedef struct packed {
        logic [6:0] dim;
        logic [4:0] id;
        logic [9:0] y;
        logic [9:0] x;
    } sprite_desc_t;

endpackage : sprite_pkg
`default_nettype wire

// File: rtl/vga_frame_edge.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_edge
//  Description : Detects the start of vertical blank. Compares the current
//                line against VBLANK_LINE and emits a one-cycle pulse on the
//                first cycle the line is inside vertical blank.
//  Ports       : clk      - system clock
//                reset    - asynchronous active-low reset
//                vcount   - current VGA line (clk domain)
//                vb_edge  - one-cycle pulse at start of vertical blank
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_edge #(
    parameter int VBLANK_LINE = 480,
    parameter int VCOUNT_W    = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [VCOUNT_W-1:0] vcount,
    output logic                vb_edge
);

    localparam logic [VCOUNT_W-1:0] C_LINE = VCOUNT_W'(VBLANK_LINE);

    logic w_vblank;
    logic r_vblank_q;

    assign w_vblank = (vcount >= C_LINE);

    // The history bit resets to "already in blank" so that leaving reset
    // while the line is inside vertical blank does not look like a new frame;
    // the blank must first end before the next edge can be reported.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vblank_q <= 1'b1;
        end else begin
            r_vblank_q <= w_vblank;
        end
    end

    assign vb_edge = w_vblank & ~r_vblank_q;

endmodule : vga_frame_edge
`default_nettype wire

// File: rtl/sprite_table_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_table_writer
//  Description : Avalon-MM slave owning the double-buffered sprite descriptor
//                table. Software writes a shadow bank; the shadow bank is
//                copied to the active bank at the start of vertical blank when
//                a commit is pending.
//  Ports       : clk, reset (async active-low)
//                chipselect/write/read/address/writedata/readdata - Avalon
//                VGA_VCOUNT          - current VGA line
//                sprite1..sprite3    - active descriptors to the renderer
//                frame_irq           - one-cycle pulse per committed swap
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_table_writer
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 3,
    parameter int VBLANK_LINE = VBLANK_LINE_DEFAULT,
    parameter int FCNT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  VGA_VCOUNT,
    output logic [31:0] sprite1,
    output logic [31:0] sprite2,
    output logic [31:0] sprite3,
    output logic        frame_irq
);

    localparam logic [2:0] C_NUM_SLOTS = 3'(NUM_SPRITES);

    sprite_desc_t       r_shadow [NUM_SPRITES];
    sprite_desc_t       r_active [NUM_SPRITES];
    logic               r_pending;
    logic               r_auto;
    logic [FCNT_W-1:0]  r_fcnt;
    logic [31:0]        r_readdata;
    logic               r_irq;

    logic               w_wr;
    logic               w_rd;
    logic               w_desc_wr;
    logic               w_ctrl_wr;
    logic               w_set_pending;
    logic               w_vb_edge;
    logic [31:0]        w_rdata;

    vga_frame_edge #(
        .VBLANK_LINE (VBLANK_LINE),
        .VCOUNT_W    (10)
    ) u_frame_edge (
        .clk     (clk),
        .reset   (reset),
        .vcount  (VGA_VCOUNT),
        .vb_edge (w_vb_edge)
    );

    assign w_wr      = chipselect & write;
    assign w_rd      = chipselect & read;
    assign w_desc_wr = w_wr & (address < C_NUM_SLOTS);
    assign w_ctrl_wr = w_wr & (address == ADDR_CTRL);

    // Setting pending has priority over the clear done by a swap, so a commit
    // requested on the swap cycle waits for the next frame.
    assign w_set_pending = (w_ctrl_wr & writedata[CTRL_COMMIT_BIT])
                         | (w_desc_wr & r_auto);

    // Descriptor banks. The active bank copies the pre-write shadow because
    // both sides use the registered values of the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_shadow[i] <= sprite_desc_t'(SPRITE_RESET_DESC);
                r_active[i] <= sprite_desc_t'(SPRITE_RESET_DESC);
            end
        end else begin
            if (w_vb_edge && r_pending) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (w_desc_wr && (address == 3'(i))) begin
                    r_shadow[i] <= sprite_desc_t'(writedata);
                end
            end
        end
    end

    // Control, status and frame pacing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= 1'b0;
            r_auto    <= 1'b0;
            r_fcnt    <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_auto <= writedata[CTRL_AUTO_BIT];
            end
            if (w_set_pending) begin
                r_pending <= 1'b1;
            end else if (w_vb_edge) begin
                r_pending <= 1'b0;
            end
            if (w_vb_edge) begin
                r_fcnt <= r_fcnt + 1'b1;
            end
            r_irq <= w_vb_edge & r_pending;
        end
    end

    // Read mux: shadow descriptors, CTRL and STATUS; holes read as zero
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (address == 3'(i)) begin
                w_rdata = r_shadow[i];
            end
        end
        case (address)
            ADDR_CTRL: begin
                w_rdata[CTRL_AUTO_BIT]   = r_auto;
                w_rdata[CTRL_COMMIT_BIT] = r_pending;
            end
            ADDR_STATUS: begin
                w_rdata[0]           = r_pending;
                w_rdata[8 +: FCNT_W] = r_fcnt;
            end
            default: ;
        endcase
    end

    // readdata holds its last value between reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rdata;
        end
    end

    assign readdata  = r_readdata;
    assign sprite1   = r_active[0];
    assign sprite2   = r_active[1];
    assign sprite3   = r_active[2];
    assign frame_irq = r_irq;

endmodule : sprite_table_writer
`default_nettype wire

// File: tb/tb_sprite_table_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_table_writer
//  Description : Directed self-checking bench for sprite_table_writer. A
//                behavioural model of the register file is compared against
//                the DUT every cycle; directed steps add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_table_writer;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        chipselect = 1'b0;
    logic        write      = 1'b0;
    logic        read       = 1'b0;
    logic [2:0]  address    = 3'd0;
    logic [31:0] writedata  = 32'd0;
    logic [9:0]  VGA_VCOUNT = 10'd0;
    logic [31:0] readdata;
    logic [31:0] sprite1, sprite2, sprite3;
    logic        frame_irq;

    int          vectors     = 0;
    int          miscompares = 0;
    int          irq_seen    = 0;
    bit          checking    = 1'b0;
    logic [9:0]  vc_cur      = 10'd0;

    sprite_table_writer u_dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .VGA_VCOUNT (VGA_VCOUNT),
        .sprite1    (sprite1),
        .sprite2    (sprite2),
        .sprite3    (sprite3),
        .frame_irq  (frame_irq)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: register file semantics in plain variables
    // ------------------------------------------------------------------
    logic [31:0] m_shadow [3];
    logic [31:0] m_active [3];
    logic [31:0] m_rdata;
    bit          m_pending, m_auto, m_prev, m_irq;
    int          m_fcnt;

    always @(posedge clk or negedge reset) begin : model
        bit vb_now, set_p, wr_en, rd_en, in_blank;
        int a;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_shadow[i] = 32'h000F_FC00;
                m_active[i] = 32'h000F_FC00;
            end
            m_pending = 0; m_auto = 0; m_irq = 0; m_fcnt = 0;
            m_rdata   = 32'd0;
            m_prev    = 1;   // leaving reset inside blank is not a new frame
        end else begin
            wr_en    = chipselect && write;
            rd_en    = chipselect && read;
            a        = int'(address);
            in_blank = (VGA_VCOUNT >= 10'd480);
            if (rd_en) begin
                if (a < 3)       m_rdata = m_shadow[a];
                else if (a == 4) m_rdata = {30'd0, m_auto, m_pending};
                else if (a == 5) m_rdata = {16'd0, m_fcnt[7:0], 7'd0, m_pending};
                else             m_rdata = 32'd0;
            end
            vb_now = in_blank && !m_prev;
            m_prev = in_blank;
            m_irq  = vb_now && m_pending;
            if (m_irq) m_active = m_shadow;
            set_p = wr_en && ((a == 4 && writedata[0]) || (a < 3 && m_auto));
            if (wr_en && a < 3)  m_shadow[a] = writedata;
            if (wr_en && a == 4) m_auto = writedata[1];
            if (set_p)       m_pending = 1;
            else if (vb_now) m_pending = 0;
            if (vb_now) m_fcnt = (m_fcnt + 1) % 256;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (checking) begin
            chk("model sprite1",   sprite1,           m_active[0]);
            chk("model sprite2",   sprite2,           m_active[1]);
            chk("model sprite3",   sprite3,           m_active[2]);
            chk("model frame_irq", {31'd0, frame_irq}, {31'd0, m_irq});
            chk("model readdata",  readdata,          m_rdata);
        end
        if (frame_irq) irq_seen++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: every input change happens on the falling edge
    // ------------------------------------------------------------------
    task automatic drive(input logic w, input logic r, input logic [2:0] a,
                         input logic [31:0] d, input logic [9:0] vc);
        @(negedge clk);
        chipselect = w | r;
        write      = w;
        read       = r;
        address    = a;
        writedata  = d;
        VGA_VCOUNT = vc;
        vc_cur     = vc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 32'd0, vc_cur);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, a, d, vc_cur);
        idle(1);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        drive(1'b0, 1'b1, a, 32'd0, vc_cur);
        idle(1);
        v = readdata;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(name, v, exp);
    endtask

    // One frame: leave blank, then enter blank with an optional bus op on the
    // very cycle vertical blank begins; returns after that edge has been taken.
    task automatic frame_op(input logic w, input logic r, input logic [2:0] a,
                            input logic [31:0] d);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 10'd0);
        drive(w, r, a, d, 10'd480);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 10'd480);
    endtask

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int irq0;

        // 1. Reset state
        repeat (3) @(negedge clk);
        reset    = 1'b1;
        checking = 1'b1;
        idle(2);
        chk("reset sprite1", sprite1, 32'h000F_FC00);
        chk("reset sprite2", sprite2, 32'h000F_FC00);
        chk("reset sprite3", sprite3, 32'h000F_FC00);
        chk("reset irq",     {31'd0, frame_irq}, 32'd0);
        rd_chk("reset STATUS", 3'd5, 32'd0);
        rd_chk("reset CTRL",   3'd4, 32'd0);

        // 2. Write without commit, then commit
        wr(3'd0, 32'h4020_2864);
        frame_op(1'b0, 1'b0, 3'd0, 32'd0);
        chk("no-commit sprite1", sprite1, 32'h000F_FC00);
        rd_chk("no-commit STATUS", 3'd5, 32'h0000_0100);
        wr(3'd4, 32'd1);
        rd_chk("commit pending", 3'd5, 32'h0000_0101);
        irq0 = irq_seen;
        frame_op(1'b0, 1'b0, 3'd0, 32'd0);
        chk("commit sprite1", sprite1, 32'h4020_2864);
        idle(2);
        chk("commit irq pulses", irq_seen - irq0, 1);
        rd_chk("commit cleared", 3'd5, 32'h0000_0200);

        // 3. AUTO commit on descriptor write
        wr(3'd4, 32'd2);
        wr(3'd2, 32'h0630_0C0A);
        rd_chk("auto pending", 3'd5, 32'h0000_0201);
        frame_op(1'b0, 1'b0, 3'd0, 32'd0);
        chk("auto sprite3", sprite3, 32'h0630_0C0A);
        rd_chk("auto STATUS", 3'd5, 32'h0000_0300);
        rd_chk("auto CTRL",   3'd4, 32'h0000_0002);

        // 4. Bus writes on the vblank-edge cycle
        wr(3'd4, 32'd0);                       // AUTO off, no commit
        wr(3'd1, 32'h1111_1111);
        wr(3'd4, 32'd1);
        frame_op(1'b1, 1'b0, 3'd1, 32'h2222_2222);
        chk("edge-wr sprite2 old", sprite2, 32'h1111_1111);
        rd_chk("edge-wr STATUS", 3'd5, 32'h0000_0400);
        wr(3'd0, 32'h3333_3333);
        wr(3'd4, 32'd1);
        frame_op(1'b1, 1'b0, 3'd4, 32'd1);     // commit while swap clears
        chk("edge-commit sprite1", sprite1, 32'h3333_3333);
        chk("edge-commit sprite2", sprite2, 32'h2222_2222);
        rd_chk("edge-commit pending", 3'd5, 32'h0000_0501);
        irq0 = irq_seen;
        frame_op(1'b0, 1'b0, 3'd0, 32'd0);
        idle(1);
        chk("second swap irq", irq_seen - irq0, 1);
        frame_op(1'b0, 1'b1, 3'd5, 32'd0);     // STATUS read on edge cycle
        chk("edge read pre-edge", readdata, 32'h0000_0600);
        rd_chk("post-edge STATUS", 3'd5, 32'h0000_0700);

        // 5. Counter wrap and unmapped addresses
        repeat (249) frame_op(1'b0, 1'b0, 3'd0, 32'd0);
        rd_chk("fcnt wrap", 3'd5, 32'd0);
        rd_chk("addr3 zero", 3'd3, 32'd0);
        rd_chk("addr6 zero", 3'd6, 32'd0);
        rd_chk("addr7 zero", 3'd7, 32'd0);
        wr(3'd6, 32'hFFFF_FFFF);
        rd_chk("addr6 wr CTRL", 3'd4, 32'd0);
        rd_chk("addr6 wr STATUS", 3'd5, 32'd0);
        rd_chk("addr6 wr shadow0", 3'd0, 32'h3333_3333);

        // 6. Reset mid-frame inside vertical blank
        wr(3'd0, 32'h5555_5555);
        wr(3'd4, 32'd1);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 10'd490);
        idle(2);
        rd_chk("pre-reset pending", 3'd5, 32'h0000_0001);
        irq0 = irq_seen;
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        idle(5);
        chk("post-reset sprite1", sprite1, 32'h000F_FC00);
        rd_chk("post-reset STATUS", 3'd5, 32'd0);
        rd_chk("post-reset shadow0", 3'd0, 32'h000F_FC00);
        chk("post-reset no irq", irq_seen - irq0, 0);
        frame_op(1'b0, 1'b0, 3'd0, 32'd0);
        rd_chk("first frame after reset", 3'd5, 32'h0000_0100);
        chk("no swap after reset", sprite1, 32'h000F_FC00);

        idle(2);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sprite_table_writer
`default_nettype wire

// File: doc/sprite_table_writer.md
Name: sprite_table_writer

Overview:
CPU-facing Avalon-MM slave that owns the sprite descriptor table feeding the sprite renderer's sprite1/sprite2/sprite3 inputs. Software writes descriptors into a shadow bank at any time. The block copies the shadow bank into the active bank only at the start of vertical blank, so the renderer never sees a half-updated frame. Provides readback, commit control and a frame counter so software can pace updates.

Parameters:
NUM_SPRITES, 3, number of descriptor slots (outputs sprite1..sprite3 fixed for NUM_SPRITES=3)
VBLANK_LINE, 480, VGA_VCOUNT value at which vertical blank begins
FCNT_W, 8, frame counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  3  word address
writedata  in  32  write data
readdata  out  32  read data, registered
VGA_VCOUNT  in  10  current VGA line, clk domain
sprite1, sprite2, sprite3  out  32  active descriptors: [31:25] dim, [24:20] id, [19:10] y, [9:0] x
frame_irq  out  1  one-cycle pulse on every committed swap

Behaviour:
- Register map (word addresses):
  - 0..2: shadow descriptor n, read/write.
  - 4: CTRL, read/write. bit0 COMMIT (write 1 sets pending; write 0 has no effect; reads return pending). bit1 AUTO (when 1, any descriptor write also sets pending).
  - 5: STATUS, read-only. bit0 pending; bits[15:8] frame counter; other bits 0.
  - 3, 6, 7: reads return 0; writes are ignored.
- Reset (reset=0, asynchronous):
  - shadow and active descriptors = 32'h000F_FC00 (y=1023, off-screen, id 0, dim 0).
  - pending=0, AUTO=0, frame counter=0, readdata=0, frame_irq=0.
- Write: takes effect on the clk edge with chipselect&write. No wait states.
- Read: chipselect&read at edge N puts the value on readdata after edge N, i.e. 1-cycle latency. readdata holds its value when not reading.
- Vblank edge:
  - vblank = (VGA_VCOUNT >= VBLANK_LINE), registered once.
  - vb_edge = vblank & ~vblank_q, asserted for one cycle per frame.
- On vb_edge:
  - frame counter increments, wrapping 8'hFF -> 0.
  - If pending=1: active <= shadow (all slots in the same cycle), pending <= 0, frame_irq=1 for exactly one cycle.
  - If pending=0: active bank is unchanged and frame_irq stays 0.
- Simultaneous events on the vb_edge cycle:
  - Descriptor write: commit copies the pre-write shadow; the write lands in shadow; pending becomes 1 only if AUTO=1.
  - CTRL write with COMMIT=1: pending=1 after the edge (set beats clear); the new commit waits for the next frame.
  - Read of STATUS returns pre-edge pending and counter.
- Writes while pending=1 are accepted and are included in the upcoming commit.
- Reset asserted mid-frame: all state returns to reset values immediately. After release, a VGA_VCOUNT already >= VBLANK_LINE does not produce vb_edge until vblank has first deasserted.
- No arithmetic on descriptor fields; all 32 bits are stored verbatim.

Decomposition:
- Package sprite_pkg:
  - descriptor field bit positions (DIM/ID/Y/X MSB/LSB)
  - register address constants (ADDR_CTRL=4, ADDR_STATUS=5)
  - CTRL bit indices
  - SPRITE_RESET_DESC=32'h000F_FC00
  - VBLANK_LINE default
  - typedef sprite_desc_t (packed struct matching the field layout)
- One sub-module, vga_frame_edge: registers vblank and emits vb_edge. It is reusable by other frame-synchronous blocks.

Test Plan:
1. Reset -> sprite1..3 = 32'h000F_FC00; read STATUS = 0; read CTRL = 0; frame_irq = 0.
2. Write addr0=32'h4020_2864, no commit; run VGA_VCOUNT through 480 -> sprite1 unchanged, STATUS[15:8]=1. Write CTRL=1, next vblank -> sprite1=32'h4020_2864, frame_irq one pulse, pending=0.
3. AUTO=1 (CTRL=2): write addr2=32'h0630_0C0A -> STATUS bit0=1 immediately; next vb_edge -> sprite3=32'h0630_0C0A.
4. Descriptor write and CTRL COMMIT write on the vb_edge cycle -> active gets old shadow; pending=1 afterwards; new value appears on the following frame.
5. Run 256 vblanks -> frame counter wraps to 0; reads of addr 3/6/7 return 0; a write to addr 6 changes nothing.
6. Assert reset during pending=1 with VGA_VCOUNT=490; release -> no swap or irq until VGA_VCOUNT drops below 480 and rises to 480 again.
